// File: rtl/pc_stack_counter_pkg.sv
// rtl/pc_stack_counter_pkg.sv - shared defaults and action encoding for pc_stack_counter
// Contents:
//   DEF_AW, DEF_DEPTH, DEF_RESET_VEC : default parameter values
//   DEF_SPW                          : sp_level width for the default depth
//   action_e                         : one-hot-free encoding of the per-edge action
//   sp_width()                       : sp_level width for any depth
package pc_stack_counter_pkg;

  localparam int DEF_AW        = 12;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_RESET_VEC = 0;
  localparam int DEF_SPW       = $clog2(DEF_DEPTH + 1);

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_INC   = 3'd1,
    ACT_JUMP  = 3'd2,
    ACT_CALL  = 3'd3,
    ACT_RET   = 3'd4,
    ACT_TAILJ = 3'd5
  } action_e;

  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_stack_counter_ret_stack.sv
// rtl/pc_stack_counter_ret_stack.sv - LIFO of return addresses indexed by fill level
// Ports:
//   clk, reset      : clock, asynchronous active-high reset (clears level only)
//   push, din       : write din at index level, level+1 (ignored when full)
//   pop             : level-1 (ignored when empty)
//   top             : entry at level-1, 0 when empty
//   level           : valid entries 0..DEPTH
//   full, empty     : level == DEPTH / level == 0
module ret_stack #(
  parameter int AW    = 12,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [AW-1:0]                din,
  output logic [AW-1:0]                top,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign wr_idx  = IW'(level);
  assign rd_idx  = IW'(level - LW'(1));
  assign top     = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else if (do_push) begin
      level <= level + LW'(1);
    end else if (do_pop) begin
      level <= level - LW'(1);
    end
  end

  // Storage needs no reset: entries above level are never observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_stack_counter.sv
// rtl/pc_stack_counter.sv - program counter with return-address stack, wrap and sticky errors
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   enable, load, call, ret, load_value : control word from decode
//   clear_err           : clear overflow/underflow (a same-edge error wins)
//   pc                  : registered program address
//   top, sp_level       : stack top (0 when empty) and fill level
//   stack_empty/full    : stack status
//   wrap                : one-cycle pulse after an increment from all-ones
//   overflow/underflow  : sticky refused-call / refused-ret flags
module pc_stack_counter
  import pc_stack_counter_pkg::*;
#(
  parameter int            AW        = DEF_AW,
  parameter int            DEPTH     = DEF_DEPTH,
  parameter logic [AW-1:0] RESET_VEC = AW'(DEF_RESET_VEC)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        load,
  input  logic [AW-1:0]               load_value,
  input  logic                        call,
  input  logic                        ret,
  input  logic                        clear_err,
  output logic [AW-1:0]               pc,
  output logic [AW-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0]  sp_level,
  output logic                        stack_empty,
  output logic                        stack_full,
  output logic                        wrap,
  output logic                        overflow,
  output logic                        underflow
);

  action_e       act;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] ret_addr;
  logic          ovf_set;
  logic          unf_set;

  // Return address wraps naturally: a call at all-ones pushes 0.
  assign ret_addr = pc + AW'(1);

  always_comb begin
    act     = ACT_NONE;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (call && ret) begin
      act = ACT_TAILJ;
    end else if (call) begin
      if (stack_full) ovf_set = 1'b1;
      else            act     = ACT_CALL;
    end else if (ret) begin
      if (stack_empty) unf_set = 1'b1;
      else             act     = ACT_RET;
    end else if (load) begin
      act = ACT_JUMP;
    end else if (enable) begin
      act = ACT_INC;
    end
  end

  always_comb begin
    pc_next = pc;
    case (act)
      ACT_INC:                      pc_next = pc + AW'(1);
      ACT_JUMP, ACT_CALL, ACT_TAILJ: pc_next = load_value;
      ACT_RET:                      pc_next = top;
      default:                      pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_VEC;
      wrap      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc        <= pc_next;
      wrap      <= (act == ACT_INC) && (pc == '1);
      overflow  <= ovf_set | (overflow & ~clear_err);
      underflow <= unf_set | (underflow & ~clear_err);
    end
  end

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (act == ACT_CALL),
    .pop   (act == ACT_RET),
    .din   (ret_addr),
    .top   (top),
    .level (sp_level),
    .full  (stack_full),
    .empty (stack_empty)
  );

endmodule

// File: tb/tb_pc_stack_counter.sv
// tb/tb_pc_stack_counter.sv - directed table-driven bench for pc_stack_counter
module tb_pc_stack_counter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        load;
  logic [11:0] load_value;
  logic        call;
  logic        ret;
  logic        clear_err;
  logic [11:0] pc;
  logic [11:0] top;
  logic [2:0]  sp_level;
  logic        stack_empty;
  logic        stack_full;
  logic        wrap;
  logic        overflow;
  logic        underflow;

  int n_total;
  int n_pass;

  pc_stack_counter #(
    .AW        (12),
    .DEPTH     (4),
    .RESET_VEC (12'h000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .load_value  (load_value),
    .call        (call),
    .ret         (ret),
    .clear_err   (clear_err),
    .pc          (pc),
    .top         (top),
    .sp_level    (sp_level),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .wrap        (wrap),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        c;
    logic        r;
    logic        l;
    logic        e;
    logic        x;
    logic [11:0] lv;
    logic [11:0] e_pc;
    logic [11:0] e_top;
    int          e_sp;
    logic        e_wrap;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic c, input logic r, input logic l, input logic e, input logic x,
                     input logic [11:0] lv, input logic [11:0] epc, input logic [11:0] etop,
                     input int esp, input logic ew, input logic eo, input logic eu);
    vec_t v;
    v.c = c; v.r = r; v.l = l; v.e = e; v.x = x; v.lv = lv;
    v.e_pc = epc; v.e_top = etop; v.e_sp = esp;
    v.e_wrap = ew; v.e_ovf = eo; v.e_unf = eu;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [11:0] epc, input logic [11:0] etop,
                           input int esp, input logic ew, input logic eo, input logic eu);
    check({tag, " pc"}, 32'(pc), 32'(epc));
    check({tag, " top"}, 32'(top), 32'(etop));
    check({tag, " sp_level"}, 32'(sp_level), 32'(esp));
    check({tag, " stack_empty"}, 32'(stack_empty), 32'(esp == 0));
    check({tag, " stack_full"}, 32'(stack_full), 32'(esp == 4));
    check({tag, " wrap"}, 32'(wrap), 32'(ew));
    check({tag, " overflow"}, 32'(overflow), 32'(eo));
    check({tag, " underflow"}, 32'(underflow), 32'(eu));
  endtask

  task automatic drive(input logic c, input logic r, input logic l, input logic e, input logic x,
                       input logic [11:0] lv);
    call = c; ret = r; load = l; enable = e; clear_err = x; load_value = lv;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 12'h000);

    //   c r l e x  lv       pc       top      sp w o u
    add(0,0,0,1,0, 12'h000, 12'h001, 12'h000, 0,0,0,0);
    add(0,0,0,1,0, 12'h000, 12'h002, 12'h000, 0,0,0,0);
    add(0,0,0,1,0, 12'h000, 12'h003, 12'h000, 0,0,0,0);
    add(1,0,0,0,0, 12'h100, 12'h100, 12'h004, 1,0,0,0);
    add(0,1,0,0,0, 12'h000, 12'h004, 12'h000, 0,0,0,0);
    add(1,0,0,0,0, 12'h200, 12'h200, 12'h005, 1,0,0,0);
    add(1,0,0,0,0, 12'h300, 12'h300, 12'h201, 2,0,0,0);
    add(1,0,0,0,0, 12'h400, 12'h400, 12'h301, 3,0,0,0);
    add(1,0,0,0,0, 12'h500, 12'h500, 12'h401, 4,0,0,0);
    add(1,0,0,0,0, 12'h600, 12'h500, 12'h401, 4,0,1,0);
    add(0,1,0,0,0, 12'h000, 12'h401, 12'h301, 3,0,1,0);
    add(0,1,0,0,0, 12'h000, 12'h301, 12'h201, 2,0,1,0);
    add(0,1,0,0,0, 12'h000, 12'h201, 12'h005, 1,0,1,0);
    add(0,1,0,0,0, 12'h000, 12'h005, 12'h000, 0,0,1,0);
    add(0,1,0,0,0, 12'h000, 12'h005, 12'h000, 0,0,1,1);
    add(0,0,0,0,1, 12'h000, 12'h005, 12'h000, 0,0,0,0);
    add(0,0,0,0,1, 12'h000, 12'h005, 12'h000, 0,0,0,0);
    add(0,1,0,0,1, 12'h000, 12'h005, 12'h000, 0,0,0,1);
    add(0,0,0,0,1, 12'h000, 12'h005, 12'h000, 0,0,0,0);
    add(0,0,1,0,0, 12'hFFF, 12'hFFF, 12'h000, 0,0,0,0);
    add(0,0,0,1,0, 12'h000, 12'h000, 12'h000, 0,1,0,0);
    add(0,0,0,0,0, 12'h000, 12'h000, 12'h000, 0,0,0,0);
    add(0,0,1,0,0, 12'hFFF, 12'hFFF, 12'h000, 0,0,0,0);
    add(1,0,0,0,0, 12'h010, 12'h010, 12'h000, 1,0,0,0);
    add(1,1,1,1,0, 12'h777, 12'h777, 12'h000, 1,0,0,0);
    add(1,0,0,0,0, 12'h020, 12'h020, 12'h778, 2,0,0,0);
    add(0,0,1,1,0, 12'h123, 12'h123, 12'h778, 2,0,0,0);
    add(0,0,0,1,0, 12'h000, 12'h124, 12'h778, 2,0,0,0);

    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 12'h000, 12'h000, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].c, vq[i].r, vq[i].l, vq[i].e, vq[i].x, vq[i].lv);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_top, vq[i].e_sp,
                vq[i].e_wrap, vq[i].e_ovf, vq[i].e_unf);
      @(negedge clk);
    end

    // Asynchronous reset between edges with two entries on the stack.
    drive(0, 0, 0, 0, 0, 12'h000);
    check("pre-async sp_level", 32'(sp_level), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    check_all("async reset", 12'h000, 12'h000, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 1, 0, 12'h000);
    @(posedge clk);
    #1;
    check_all("post-reset inc", 12'h001, 12'h000, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_stack_counter.md
# pc_stack_counter

Parametrised program counter with an integrated return-address stack for the 4-bit processor datapath. It supersedes the fixed 12-bit counter with these additions: synchronous load, call/return with a LIFO of return addresses, wrap detection, and sticky overflow/underflow error flags. It sits between the decode ROM control word and the program-memory address bus.

## Interface
Parameters:
- AW, 12, address width in bits (≥2)
- DEPTH, 4, return-stack entries (≥1)
- RESET_VEC, 0, value `pc` takes on reset (AW bits)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  increment `pc` by 1
- load  in  1  jump: `pc <= load_value`
- load_value  in  AW  jump/call target
- call  in  1  push return address, jump to `load_value`
- ret  in  1  pop top of stack into `pc`
- clear_err  in  1  clear sticky error flags
- pc  out  AW  current program address (registered)
- top  out  AW  current top-of-stack entry; 0 when empty
- sp_level  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH
- stack_empty  out  1  `sp_level == 0`
- stack_full  out  1  `sp_level == DEPTH`
- wrap  out  1  one-cycle pulse: previous edge incremented `pc` from all-ones to 0
- overflow  out  1  sticky: a call was refused because the stack was full
- underflow  out  1  sticky: a ret was refused because the stack was empty

## Operation
- Reset values: `pc` = RESET_VEC, `sp_level` = 0, `stack_empty` = 1, `stack_full` = 0, `top` = 0, `wrap` = 0, `overflow` = 0, `underflow` = 0. Stack storage contents are don't-care.
- Per-edge priority, first match wins:
  1. **call & ret**: tail-jump. `pc <= load_value`; stack untouched; no error.
  2. **call**:
     - Not full: push (`pc`+1) mod 2^AW, then `pc <= load_value`.
     - Full: nothing changes and `overflow` is set.
  3. **ret**:
     - Not empty: `pc <= top`, then pop.
     - Empty: nothing changes and `underflow` is set.
  4. **load**: `pc <= load_value`.
  5. **enable**: `pc <= pc + 1` mod 2^AW. If `pc` was all-ones, `wrap` is 1 in the following cycle.
  6. **otherwise**: hold.
- `wrap` is 0 on every edge that does not perform a rule-5 increment from all-ones.
- `load` and `enable` are ignored whenever call or ret is asserted.
- `clear_err` zeroes both sticky flags. If an error is raised on the same edge, set wins for that flag.
- Return address arithmetic is truncated to AW bits, so a call at address all-ones pushes 0.
- The stack is a LIFO indexed by `sp_level`. `top` is combinational from the storage at index `sp_level`−1.

## Timing
- Every action completes in one cycle. `pc`, `sp_level`, and the flags are visible after the edge.
- `top` reflects a push or pop in the same cycle that `sp_level` changes.
- No input handshake. Inputs are sampled only at the rising edge.
- Reset asserted mid-operation clears state immediately, without waiting for `clk`. Release is synchronous to the next edge, and the first action is taken at the first edge after deassertion.
- Back-to-back call/ret every cycle is supported at full rate. Push followed by pop returns exactly the pushed value.

## Structure
- Shared package/header holds:
  - default AW, DEPTH, RESET_VEC constants
  - a localparam for the `sp_level` width
  - an action encoding (NONE, INC, JUMP, CALL, RET, TAILJ) used by the priority decoder
- Sub-module **ret_stack**, parametrised by AW and DEPTH:
  - inputs: `clk`, `reset`, `push`, `pop`, `din`
  - outputs: `top`, `level`, `full`, `empty`
  - it never accepts push-when-full or pop-when-empty; the top level gates these
- The top level owns the `pc` register, the priority decoder, `wrap`, and the sticky flags.

## Test plan
All scenarios use AW=12, DEPTH=4, RESET_VEC=0.
- **Reset/increment**: reset, then 3 cycles of enable → `pc` = 0x003, `stack_empty` = 1, all flags 0.
- **Call/return**: `load_value` = 0x100 with call while `pc` = 0x003 → `pc` = 0x100, `top` = 0x004, `sp_level` = 1; then ret → `pc` = 0x004, `sp_level` = 0.
- **Overflow**: 4 nested calls → `stack_full`. A 5th call → `pc` unchanged, `sp_level` = 4, `overflow` = 1. Then 4 rets → return addresses come back in LIFO order.
- **Underflow and clear**: ret when empty → `underflow` = 1, `pc` unchanged. `clear_err` with no error → 0. `clear_err` together with a ret on empty → stays 1.
- **Wrap**: load 0xFFF then enable → `pc` = 0x000 and `wrap` = 1 for exactly one cycle. Call at `pc` = 0xFFF → pushed `top` = 0x000.
- **Simultaneous and async reset**:
  - call+ret+load+enable on one edge → `pc` = `load_value`, `sp_level` unchanged.
  - reset pulsed between clock edges with `sp_level` = 2 → all outputs return to their reset values before the next edge.
